// File: rtl/sar_search.sv
// Successive-approximation search engine: drives a guess into an external
// magnitude comparator and binary-searches on its g/e/l flags until equality.
module sar_search #(
    parameter int WIDTH = 4,
    parameter int STEPW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             g,
    input  logic             e,
    input  logic             l,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] found,
    output logic [STEPW-1:0] steps,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_EVAL  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] MAX_V = '1;
    localparam logic [WIDTH-1:0] MID_V = MAX_V >> 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] found_q, found_d;
    logic [STEPW-1:0] steps_q, steps_d;
    logic [WIDTH:0]   sum;
    logic [2:0]       flags;

    // Midpoint sum carries one extra bit so lo+hi never wraps.
    assign sum   = {1'b0, lo_q} + {1'b0, hi_q};
    assign flags = {g, e, l};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= MAX_V;
            guess_q <= '0;
            found_q <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            guess_q <= guess_d;
            found_q <= found_d;
            steps_q <= steps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        guess_d = guess_q;
        found_d = found_q;
        steps_d = steps_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = MAX_V;
                    guess_d = MID_V;
                    steps_d = '0;
                    found_d = '0;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                // Flags describe the guess registered on the previous edge.
                steps_d = steps_q + 1'b1;
                case (flags)
                    3'b010: begin
                        found_d = guess_q;
                        state_d = S_DONE;
                    end
                    3'b100: begin
                        if (guess_q == MAX_V) begin
                            state_d = S_ERR;
                        end else begin
                            lo_d    = guess_q + 1'b1;
                            state_d = (lo_d > hi_q) ? S_ERR : S_DRIVE;
                        end
                    end
                    3'b001: begin
                        if (guess_q == '0) begin
                            state_d = S_ERR;
                        end else begin
                            hi_d    = guess_q - 1'b1;
                            state_d = (lo_q > hi_d) ? S_ERR : S_DRIVE;
                        end
                    end
                    default: state_d = S_ERR;
                endcase
            end
            S_DRIVE: begin
                guess_d = sum[WIDTH:1];
                state_d = S_EVAL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign guess     = guess_q;
    assign found     = found_q;
    assign steps     = steps_q;
    assign busy      = (state_q == S_DRIVE) || (state_q == S_EVAL);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign dbg_state = state_q;

endmodule
